// File: rtl/yah_pkg.sv
// Shared definitions for the yah_processor front end: data widths, reset PC
// and the packed fetch-queue entry {inst, pc, fault}.
package yah_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] YAH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Entry layout, LSB first: fault, pc, inst
  localparam int ENTRY_W   = 65;
  localparam int FAULT_BIT = 0;
  localparam int PC_LSB    = 1;
  localparam int INST_LSB  = 33;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(input logic [31:0] inst,
                                              input logic [31:0] pc,
                                              input logic        fault);
    fetch_entry_t e;
    e.inst  = inst;
    e.pc    = pc;
    e.fault = fault;
    return e;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; flush wins over push and pop.
module fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == (PTR_W+1)'(DEPTH));
  assign count_o   = cnt_q;
  assign data_o    = mem_q[rd_q];
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Pointer and count update; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push_s) begin
        wr_q <= wr_q + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage write; slots are never read while empty, so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push_s && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: own PC, one fetch per cycle into fetch_fifo,
// redirect flush and misaligned-target fault. Macro FETCH_BYPASS_EN enables
// the empty-FIFO combinational bypass from memory to decode.
module fetch_queue
  import yah_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          LINE_W   = 13,
  parameter logic [31:0] RESET_PC = YAH_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [LINE_W-1:0]      mem_line,
  input  logic [31:0]            mem_data,
  input  logic                   redirect,
  input  logic [31:0]            redirect_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic [31:0]            out_pc,
  output logic                   out_fault,
  output logic [$clog2(DEPTH):0] occupancy
);

  logic [31:0]       pc_q;
  logic [31:0]       pc_d;
  logic              halted_q;
  logic              halted_d;
  fetch_entry_t      last_q;
  fetch_entry_t      last_d;
  fetch_entry_t      head_s;
  fetch_entry_t      push_entry_s;
  fetch_entry_t      cur_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              fault_s;
  logic              pop_s;
  logic              push_ok_s;
  logic              push_fifo_s;
  logic              byp_valid_s;
  logic              byp_take_s;

  assign mem_line     = pc_q[LINE_W+1:2];
  // A misaligned PC can only come from a redirect; it fetches a fault entry instead of memory
  assign fault_s      = (pc_q[1:0] != 2'b00);
  assign push_entry_s = make_entry(fault_s ? 32'h0000_0000 : mem_data, pc_q, fault_s);

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect),
    .push_i  (push_fifo_s),
    .pop_i   (pop_s),
    .data_i  (push_entry_s),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (occupancy)
  );

  // Handshake, push eligibility and output selection
  always_comb begin
`ifdef FETCH_BYPASS_EN
    byp_valid_s = fifo_empty_s && !halted_q && !redirect;
`else
    byp_valid_s = 1'b0;
`endif
    byp_take_s  = byp_valid_s && out_ready;
    pop_s       = !fifo_empty_s && out_ready;
    push_ok_s   = !redirect && !halted_q && (!fifo_full_s || pop_s);
    push_fifo_s = push_ok_s && !byp_take_s;

    if (!fifo_empty_s) begin
      cur_s = head_s;
    end else if (byp_valid_s) begin
      cur_s = push_entry_s;
    end else begin
      cur_s = last_q;
    end
    last_d    = cur_s;
    out_valid = !fifo_empty_s || byp_valid_s;
    out_inst  = cur_s.inst;
    out_pc    = cur_s.pc;
    out_fault = cur_s.fault;
  end

  // PC and halt next-state; redirect has priority over any fetch
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    if (redirect) begin
      pc_d     = redirect_addr;
      halted_d = 1'b0;
    end else if (push_ok_s) begin
      if (fault_s) begin
        halted_d = 1'b1;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end else begin
      pc_d     = pc_q;
      halted_d = halted_q;
    end
  end

  // Fetch state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      last_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: memory returns the line index, a
// scoreboard of expected {inst, pc, fault} is compared against accepted beats.
module tb_fetch_queue;

  localparam int LINE_W = 13;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [LINE_W-1:0] mem_line;
  logic [31:0]       mem_data;
  logic              redirect;
  logic [31:0]       redirect_addr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [31:0]       out_pc;
  logic              out_fault;
  logic [2:0]        occupancy;

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t exp_q[$];
  ent_t obs_q[$];
  ent_t got;
  ent_t want;

  always #5 clk = ~clk;

  assign mem_data = {{(32-LINE_W){1'b0}}, mem_line};

  fetch_queue #(.DEPTH(DEPTH), .LINE_W(LINE_W), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_line      (mem_line),
    .mem_data      (mem_data),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_fault     (out_fault),
    .occupancy     (occupancy)
  );

  // Record every beat decode accepts; sampled mid-cycle, away from the edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && redirect === 1'b0)
      obs_q.push_back(ent_t'({out_inst, out_pc, out_fault}));
  end

  function automatic ent_t seq(input logic [31:0] pc);
    ent_t e;
    e.inst  = {19'd0, pc[14:2]};
    e.pc    = pc;
    e.fault = 1'b0;
    return e;
  endfunction

  task automatic load_exp(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(seq(base + 32'(4 * k)));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_addr = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_cmp++; if (out_inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", out_inst); end
    n_cmp++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    n_cmp++; if (out_fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", out_fault); end
    n_cmp++; if (mem_line !== 13'd0) begin n_bad++; $display("FAIL reset_line: got %h want 0", mem_line); end
  endtask

  task automatic test_stream();
    obs_q.delete();
    load_exp(32'h0, 16);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (8) begin
      @(posedge clk); #2;
      n_cmp++; if (occupancy > 3'd1) begin n_bad++; $display("FAIL stream_occ: got %0d want <=1", occupancy); end
    end
    n_cmp++; if (obs_q.size() < 6) begin n_bad++; $display("FAIL stream_rate: got %0d beats want >=6", obs_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL stream_beat: got %h want %h", got, want); end
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    rst_n = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    n_cmp++; if (occupancy !== 3'd4) begin n_bad++; $display("FAIL bp_occ: got %0d want 4", occupancy); end
    n_cmp++; if (mem_line !== 13'd4) begin n_bad++; $display("FAIL bp_line: got %0d want 4", mem_line); end
    n_cmp++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_head: got %h/%b want 0/1", out_pc, out_valid); end
    obs_q.delete();
    load_exp(32'h0, 8);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++; if (obs_q.size() != 5) begin n_bad++; $display("FAIL bp_count: got %0d want 5", obs_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL bp_beat: got %h want %h", got, want); end
    end
  endtask

  task automatic test_redirect();
    @(posedge clk); #1;
    redirect = 1'b1; redirect_addr = 32'h300;
    @(posedge clk); #1;
    redirect = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if (occupancy !== 3'd3) begin n_bad++; $display("FAIL redir_fill: got %0d want 3", occupancy); end
    redirect = 1'b1; redirect_addr = 32'h100; out_ready = 1'b1;
    obs_q.delete();
    load_exp(32'h100, 16);
    @(posedge clk); #1;
    redirect = 1'b0;
    #1;
    n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL redir_occ: got %0d want 0", occupancy); end
`ifdef FETCH_BYPASS_EN
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin n_bad++; $display("FAIL redir_n1: got %b/%h want 1/100", out_valid, out_pc); end
`else
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_n1: got %b want 0", out_valid); end
    @(posedge clk); #2;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin n_bad++; $display("FAIL redir_n2: got %b/%h want 1/100", out_valid, out_pc); end
`endif
    repeat (6) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++; if (obs_q.size() < 5) begin n_bad++; $display("FAIL redir_count: got %0d want >=5", obs_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL redir_beat: got %h want %h", got, want); end
    end
  endtask

  task automatic test_fault();
    @(posedge clk); #1;
    out_ready = 1'b1; redirect = 1'b1; redirect_addr = 32'h102;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(ent_t'({32'h0, 32'h102, 1'b1}));
    @(posedge clk); #1;
    redirect = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL fault_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL fault_beat: got %h want %h", got, want); end
    end
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin n_bad++; $display("FAIL fault_halt: got %b/%0d want 0/0", out_valid, occupancy); end
    n_cmp++; if (out_fault !== 1'b1 || out_pc !== 32'h102) begin n_bad++; $display("FAIL fault_hold: got %b/%h want 1/102", out_fault, out_pc); end
    redirect = 1'b1; redirect_addr = 32'h0;
    obs_q.delete();
    load_exp(32'h0, 16);
    @(posedge clk); #1;
    redirect = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    n_cmp++; if (obs_q.size() < 4) begin n_bad++; $display("FAIL resume_count: got %0d want >=4", obs_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL resume_beat: got %h want %h", got, want); end
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    out_ready = 1'b0; redirect = 1'b1; redirect_addr = 32'h200;
    @(posedge clk); #1;
    redirect = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (occupancy !== 3'd2 || out_pc !== 32'h200) begin n_bad++; $display("FAIL arst_fill: got %0d/%h want 2/200", occupancy, out_pc); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin n_bad++; $display("FAIL arst_now: got %b/%0d want 0/0", out_valid, occupancy); end
    n_cmp++; if (mem_line !== 13'd0 || out_pc !== 32'h0) begin n_bad++; $display("FAIL arst_pc: got %h/%h want 0/0", mem_line, out_pc); end
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    obs_q.delete();
    load_exp(32'h0, 16);
    repeat (6) @(posedge clk);
    #2;
    n_cmp++; if (obs_q.size() < 4) begin n_bad++; $display("FAIL arst_count: got %0d want >=4", obs_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL arst_beat: got %h want %h", got, want); end
    end
  endtask

  task automatic test_bypass_latency();
    @(posedge clk); #1;
    out_ready = 1'b0; redirect = 1'b1; redirect_addr = 32'h40;
    @(posedge clk); #1;
    redirect = 1'b0;
    #1;
`ifdef FETCH_BYPASS_EN
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== 32'h10) begin n_bad++; $display("FAIL byp_n1: got %b/%h/%h want 1/40/10", out_valid, out_pc, out_inst); end
    n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL byp_occ: got %0d want 0", occupancy); end
`else
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_n1: got %b want 0", out_valid); end
    @(posedge clk); #2;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== 32'h10) begin n_bad++; $display("FAIL lat_n2: got %b/%h/%h want 1/40/10", out_valid, out_pc, out_inst); end
`endif
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    redirect = 1'b1; redirect_addr = 32'h800;
    obs_q.delete();
    load_exp(32'h800, 100);
    @(posedge clk); #1;
    redirect = 1'b0;
    for (int c = 0; c < 80; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    n_cmp++; if (obs_q.size() < 10) begin n_bad++; $display("FAIL b2b_count: got %0d want >=10", obs_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL b2b_beat: got %h want %h", got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_async_reset();
    test_bypass_latency();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
